// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
//   state_e : sequencer FSM states
//   cw()    : width needed to hold the values 0..n inclusive
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SEQ    = 2'd1,
        DONE   = 2'd2,
        SWHOLD = 2'd3
    } state_e;

    function automatic int cw(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchroniser: asynchronous clear, shifts in a constant 1 each clk edge.
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   sync_ok out high once SYNC_STAGES edges have passed with reset low
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_ok
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Only sync_q[0] can go metastable when reset releases near an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staggered reset sequencer. Asserts all channels asynchronously on reset,
// releases them one by one (channel 0 first) RELEASE_GAP cycles apart after
// the synchroniser fills. A sampled sw_rst_req in SEQ/DONE re-asserts all
// channels, holds RELEASE_GAP edges, then re-runs the release sequence.
//   clk          in  clock
//   reset        in  asynchronous active-high reset
//   sw_rst_req   in  synchronous software reset request
//   rst_out      out per-channel active-high reset
//   all_released out every channel released
//   busy         out sequencer not in DONE
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int RELEASE_GAP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_released,
    output logic              busy
);

    localparam int CW = cw(RELEASE_GAP);
    localparam int IW = cw(NUM_CH);

    logic              sync_ok;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              all_rel_q, all_rel_d;
    logic              busy_q, busy_d;
    logic              step;

    rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .sync_ok (sync_ok)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        step    = 1'b0;

        unique case (state_q)
            // The edge that first observes sync_ok already counts as gap
            // cycle 0, so channel i releases at SYNC_STAGES+(i+1)*RELEASE_GAP.
            // cnt/idx are still 0 here since HOLD is only entered by reset.
            HOLD: begin
                if (sync_ok) begin
                    state_d = SEQ;
                    step    = 1'b1;
                end
            end
            SEQ: begin
                if (sw_rst_req) begin
                    state_d = SWHOLD;
                    cnt_d   = '0;
                    rst_d   = '1;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (sw_rst_req) begin
                    state_d = SWHOLD;
                    cnt_d   = '0;
                    rst_d   = '1;
                end
            end
            SWHOLD: begin
                if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase

        if (step) begin
            if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx_q == IW'(i)) rst_d[i] = 1'b0;
                end
                cnt_d = '0;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NUM_CH - 1)) state_d = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // rst_out is all zero exactly in DONE, so flags follow the next state.
        all_rel_d = (state_d == DONE);
        busy_d    = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_q     <= rst_d;
            all_rel_q <= all_rel_d;
            busy_q    <= busy_d;
        end
    end

    assign rst_out      = rst_q;
    assign all_released = all_rel_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

    localparam int S = 2;
    localparam int N = 4;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sw_rst_req;
    logic [N-1:0] rst_out;
    logic         all_released;
    logic         busy;

    logic         reset2;
    logic         sw2;
    logic [0:0]   rst_out2;
    logic         all_rel2;
    logic         busy2;

    int errs   = 0;
    int checks = 0;

    // Reference model, in edge-count terms:
    //   e      : edges since the last reset de-assertion
    //   anchor : rst_out[i] is clear once e >= anchor + (i+1)*G
    //   elig   : first edge at which a software request is honoured
    int e, anchor, elig;
    bit in_rst;

    always #5 clk = ~clk;

    rst_sequencer #(.SYNC_STAGES(S), .NUM_CH(N), .RELEASE_GAP(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req   (sw_rst_req),
        .rst_out      (rst_out),
        .all_released (all_released),
        .busy         (busy)
    );

    rst_sequencer #(.SYNC_STAGES(3), .NUM_CH(1), .RELEASE_GAP(1)) dut2 (
        .clk          (clk),
        .reset        (reset2),
        .sw_rst_req   (sw2),
        .rst_out      (rst_out2),
        .all_released (all_rel2),
        .busy         (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t e=%0d: got %0h want %0h", tag, $time, e, act, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] r;
        r = '1;
        if (!in_rst)
            for (int i = 0; i < N; i++)
                if (e >= anchor + (i + 1) * G) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic exp_all();
        return !in_rst && (e >= anchor + N * G);
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".rst"},  32'(rst_out),      32'(exp_rst()));
        chk({tag, ".all"},  32'(all_released), 32'(exp_all()));
        chk({tag, ".busy"}, 32'(busy),         32'(!exp_all()));
    endtask

    // One clock: drive sw, advance model at the edge, check at negedge.
    task automatic tick(input bit sw);
        sw_rst_req = sw;
        @(posedge clk);
        if (!in_rst) begin
            e++;
            if (sw && e >= elig) begin
                anchor = e + G;
                elig   = e + G + 1;
            end
        end
        @(negedge clk);
        check_outs("tick");
    endtask

    // Assert reset between edges, confirm the outputs react with no edge,
    // hold for some cycles, then release mid-cycle.
    task automatic async_reset(input int hold);
        #2;
        reset  = 1'b1;
        in_rst = 1'b1;
        #1;
        check_outs("async");
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("inrst");
        end
        #2;
        reset  = 1'b0;
        in_rst = 1'b0;
        e      = 0;
        anchor = S;
        elig   = S + 2;
    endtask

    initial begin
        reset      = 1'b1;
        reset2     = 1'b1;
        sw_rst_req = 1'b0;
        sw2        = 1'b0;
        in_rst     = 1'b1;
        e = 0; anchor = S; elig = S + 2;
        #1;
        check_outs("por");
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("por_hold");
        end
        #2;
        reset  = 1'b0;
        in_rst = 1'b0;

        // Power-on release, then single-cycle request at edge 30 in DONE,
        // plus an ignored request at edge 32 inside SWHOLD.
        repeat (29) tick(1'b0);
        chk("done_by_29", 32'(rst_out), 32'h0);
        tick(1'b1);
        chk("sw_at_30", 32'(rst_out), 32'hf);
        tick(1'b0);
        tick(1'b1);
        repeat (23) tick(1'b0);

        // Mid-sequence reset after edge 11, with a request during HOLD.
        async_reset(2);
        tick(1'b0);
        tick(1'b1);
        repeat (9) tick(1'b0);
        chk("mid_seq_11", 32'(rst_out), 32'hc);
        async_reset(1);
        repeat (25) tick(1'b0);

        // Randomized requests and resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) async_reset($urandom_range(1, 3));
            else tick($urandom_range(0, 9) == 0);
        end

        // SYNC_STAGES=3, NUM_CH=1, RELEASE_GAP=1 instance.
        chk("p2_rst_in_reset", 32'(rst_out2), 32'h1);
        chk("p2_busy_in_reset", 32'(busy2), 32'h1);
        #2;
        reset2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("p2_rst", 32'(rst_out2), (k >= 4) ? 32'h0 : 32'h1);
            chk("p2_all", 32'(all_rel2), (k >= 4) ? 32'h1 : 32'h0);
            chk("p2_busy", 32'(busy2),   (k >= 4) ? 32'h0 : 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
